exe_mem_pipe_reg: RTL and testbench
===================================

// Module: exe_mem_pipe_reg
// PURPOSE
// - Pipeline register between the EXE stage and the MEM stage of the 5-stage ARM core.
// - Captures the EXE results and control, and drives the MEM stage inputs (wb/mem enables, alu result, rm value, dest).
// - Holds its contents while a multi-cycle SRAM access is outstanding (mem_ready low).
// - Generates freeze for the upstream stages, a saturating stall-cycle counter and a sticky SRAM-timeout flag.
// PARAMETERS
// - DATA_W   32  width of alu_result / rm_val
// - REG_W     4  width of destination register index
// - CNT_W    16  width of stall_cycles counter
// - TIMEOUT  64  consecutive not-ready cycles in WAIT that set mem_timeout (>=2)
// PORTS
// - clk             in   1       single clock; all state updates on rising edge
// - rst             in   1       asynchronous, active-low reset
// - exe_valid       in   1       EXE stage holds a real instruction (0 = bubble)
// - exe_wb_en       in   1       write-back enable from EXE
// - exe_mem_r_en    in   1       load request from EXE
// - exe_mem_w_en    in   1       store request from EXE
// - exe_alu_result  in   DATA_W  address / ALU result from EXE
// - exe_rm_val      in   DATA_W  store data from EXE
// - exe_dest        in   REG_W   destination register from EXE
// - mem_ready       in   1       SRAM controller ready; 1 = no access pending or access completes this cycle
// - valid           out  1       registered instruction valid
// - wb_en           out  1       to MEM stage; also hazard/forwarding unit
// - mem_r_en        out  1       to MEM stage / SRAM controller
// - mem_w_en        out  1       to MEM stage / SRAM controller
// - alu_result      out  DATA_W  to MEM stage
// - rm_val          out  DATA_W  to MEM stage
// - dest            out  REG_W   to MEM stage; also forwarding unit
// - freeze          out  1       combinational; 1 = upstream stages (PC, IF/ID, ID/EXE) must hold
// - stall_cycles    out  CNT_W   saturating count of frozen cycles since reset
// - mem_timeout     out  1       sticky error: SRAM did not respond within TIMEOUT cycles
// BEHAVIOUR
// - Reset (rst=0, async): all outputs and registers 0, FSM = IDLE, counters 0; applies mid-access (access is abandoned).
// - mem_op = valid & (mem_r_en | mem_w_en); freeze = mem_op & ~mem_ready (pure combinational, no registered delay).
// - Load: on each edge with freeze=0, all payload registers take EXE inputs; valid <= exe_valid.
// - Bubble: exe_valid=0 loads wb_en, mem_r_en, mem_w_en = 0 (payload data don't-care, but loaded).
// - Hold: on each edge with freeze=1, all payload registers keep their value (enables stay stable for the SRAM controller).
// - Latency: 1 cycle EXE->output when not frozen; an N-cycle SRAM access holds the entry for N cycles.
// - FSM (2 states):
//     IDLE: freeze=1 -> WAIT, wait_cnt<=1; else stay.
//     WAIT: mem_ready=1 -> IDLE, wait_cnt<=0 (entry retires, next EXE entry loads the same edge);
//           mem_ready=0 -> stay, wait_cnt<=wait_cnt+1 (saturate at TIMEOUT).
// - mem_timeout: set when in WAIT and wait_cnt reaches TIMEOUT; cleared only by reset; does not force release (hold continues).
// - stall_cycles: +1 on every edge with freeze=1; saturates at 2^CNT_W-1; never wraps.
// - Back-to-back memory ops: ready=1 on completion cycle retires op k and loads op k+1 on the same edge; no idle cycle inserted.
// - Bubble or non-memory entry: freeze never asserts regardless of mem_ready.
// - Read and write enables set together: treated as a mem_op, passed through unchanged (the SRAM controller arbitrates).
// - Inputs from EXE are ignored while frozen (upstream holds them stable by contract).
// STRUCTURE
// - Shared package arm_pkg: DATA_W/REG_W constants, typedef exe_mem_bus_t (packed struct of wb_en, mem_r_en, mem_w_en, alu_result,
//   rm_val, dest), typedef enum {IDLE, WAIT} mem_wait_state_t.
// - One sub-module: sat_counter (parameter WIDTH, inc, clr, out, saturating); instanced for stall_cycles and wait_cnt.
// - Top contains the payload register, freeze logic, FSM and timeout flag.
// TESTING
// - Reset: drive inputs nonzero, pulse rst=0 mid-cycle -> all outputs 0 immediately (async), FSM IDLE, stall_cycles=0.
// - Pass-through: ALU op exe_valid=1, wb_en=1, alu_result=32'h0000_1234, dest=4'd5, mem_ready=1 -> next cycle same values, freeze=0.
// - Load stall: load at addr 32'h400, mem_ready low 5 cycles then high -> outputs held 5 cycles, freeze=1 5 cycles, stall_cycles=5,
//   following EXE entry loads on the ready edge.
// - Back-to-back: store then load, each ready after 3 cycles -> no gap cycle between them, stall_cycles=6, valid stays 1.
// - Timeout: load with mem_ready held 0 for TIMEOUT+3 cycles -> mem_timeout rises after TIMEOUT cycles in WAIT, stays 1 after ready;
//   cleared only by reset.
// - Bubble + reset mid-access: exe_valid=0 with mem_r_en=1 -> freeze stays 0; assert rst during WAIT -> freeze=0, FSM IDLE, enables 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types for the ARM core pipeline: widths,
// the EXE->MEM payload bundle and the memory-wait FSM states.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rm_val;
    logic [REG_W-1:0]  dest;
  } exe_mem_bus_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_wait_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping;
// clr wins over inc.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (clr) begin
      out <= '0;
    end else if (inc && out != MAX) begin
      out <= out + 1'b1;
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE/MEM pipeline register: holds its entry while an SRAM
// access is pending, freezes upstream, tracks stalls/timeouts.
module exe_mem_pipe_reg
  import arm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic              exe_mem_w_en,
  input  logic [DATA_W-1:0] exe_alu_result,
  input  logic [DATA_W-1:0] exe_rm_val,
  input  logic [REG_W-1:0]  exe_dest,
  input  logic              mem_ready,
  output logic              valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rm_val,
  output logic [REG_W-1:0]  dest,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              mem_timeout
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_MAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

  exe_mem_bus_t    d;
  exe_mem_bus_t    q;
  mem_wait_state_t state;
  mem_wait_state_t state_n;
  logic            mem_op;
  logic            wait_inc;
  logic            wait_clr;
  logic            to_hit;
  logic [WW-1:0]   wait_cnt;

  // Bubbles must never carry live enables downstream.
  always_comb begin
    d            = '0;
    d.wb_en      = exe_valid & exe_wb_en;
    d.mem_r_en   = exe_valid & exe_mem_r_en;
    d.mem_w_en   = exe_valid & exe_mem_w_en;
    d.alu_result = exe_alu_result;
    d.rm_val     = exe_rm_val;
    d.dest       = exe_dest;
  end

  assign mem_op = valid & (q.mem_r_en | q.mem_w_en);
  assign freeze = mem_op & ~mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (!freeze) begin
      q     <= d;
      valid <= exe_valid;
    end
  end

  assign wb_en      = q.wb_en;
  assign mem_r_en   = q.mem_r_en;
  assign mem_w_en   = q.mem_w_en;
  assign alu_result = q.alu_result;
  assign rm_val     = q.rm_val;
  assign dest       = q.dest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (freeze) state_n = WAIT;
      WAIT: if (mem_ready) state_n = IDLE;
    endcase
  end

  // Flag rises on the edge where wait_cnt reaches TIMEOUT.
  always_comb begin
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    to_hit   = 1'b0;
    unique case (state)
      IDLE: wait_inc = freeze;
      WAIT: begin
        if (mem_ready) begin
          wait_clr = 1'b1;
        end else begin
          wait_inc = 1'b1;
          to_hit   = (wait_cnt == TO_LAST);
        end
      end
    endcase
  end

  sat_counter #(
    .WIDTH(WW),
    .MAX  (TO_MAX)
  ) u_wait_cnt (
    .clk(clk),
    .rst(rst),
    .inc(wait_inc),
    .clr(wait_clr),
    .out(wait_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(freeze),
    .clr(1'b0),
    .out(stall_cycles)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_timeout <= 1'b0;
    end else if (to_hit) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg; stall counter narrowed
// to 3 bits so saturation is reachable.
module tb_exe_mem_pipe_reg;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        exe_valid;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic        exe_mem_w_en;
  logic [31:0] exe_alu_result;
  logic [31:0] exe_rm_val;
  logic [3:0]  exe_dest;
  logic        mem_ready;
  logic        valid;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_result;
  logic [31:0] rm_val;
  logic [3:0]  dest;
  logic        freeze;
  logic [CNT_W-1:0] stall_cycles;
  logic        mem_timeout;

  int checks = 0;
  int fails  = 0;

  exe_mem_pipe_reg #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exe_valid     (exe_valid),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_r_en  (exe_mem_r_en),
    .exe_mem_w_en  (exe_mem_w_en),
    .exe_alu_result(exe_alu_result),
    .exe_rm_val    (exe_rm_val),
    .exe_dest      (exe_dest),
    .mem_ready     (mem_ready),
    .valid         (valid),
    .wb_en         (wb_en),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .alu_result    (alu_result),
    .rm_val        (rm_val),
    .dest          (dest),
    .freeze        (freeze),
    .stall_cycles  (stall_cycles),
    .mem_timeout   (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #3 rst = 1'b0;
    #1 rst = 1'b1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic r,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] rm, input logic [3:0] d);
    exe_valid      = v;
    exe_wb_en      = wb;
    exe_mem_r_en   = r;
    exe_mem_w_en   = w;
    exe_alu_result = a;
    exe_rm_val     = rm;
    exe_dest       = d;
  endtask

  initial begin
    // reset with busy-looking inputs
    rst = 1'b0;
    mem_ready = 1'b0;
    drive(1, 1, 1, 1, 32'hffff_ffff, 32'hffff_ffff, 4'hf);
    #12;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_alu", alu_result, 0);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_to", 32'(mem_timeout), 0);
    rst = 1'b1;
    drive(1, 1, 1, 0, 32'h100, 32'h0, 4'd1);
    step();
    chk("pre_valid", 32'(valid), 1);
    chk("pre_freeze", 32'(freeze), 1);
    step();
    chk("pre_stall", 32'(stall_cycles), 1);
    #3 rst = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 0);
    chk("async_r_en", 32'(mem_r_en), 0);
    chk("async_freeze", 32'(freeze), 0);
    chk("async_stall", 32'(stall_cycles), 0);
    chk("async_alu", alu_result, 0);
    #2 rst = 1'b1;

    // pass-through ALU op
    mem_ready = 1'b1;
    drive(1, 1, 0, 0, 32'h0000_1234, 32'h0, 4'd5);
    step();
    chk("pt_valid", 32'(valid), 1);
    chk("pt_wb", 32'(wb_en), 1);
    chk("pt_alu", alu_result, 32'h1234);
    chk("pt_dest", 32'(dest), 5);
    chk("pt_freeze", 32'(freeze), 0);

    // load stalled for 5 cycles
    mem_ready = 1'b0;
    drive(1, 1, 1, 0, 32'h400, 32'h0, 4'd3);
    step();
    drive(1, 1, 0, 0, 32'h500, 32'h0, 4'd7);
    for (int i = 0; i < 5; i++) begin
      chk("ld_freeze", 32'(freeze), 1);
      chk("ld_alu", alu_result, 32'h400);
      chk("ld_dest", 32'(dest), 3);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_rel_freeze", 32'(freeze), 0);
    chk("ld_rel_alu", alu_result, 32'h400);
    chk("ld_stall", 32'(stall_cycles), 5);
    step();
    chk("ld_next_alu", alu_result, 32'h500);
    chk("ld_next_dest", 32'(dest), 7);
    chk("ld_next_r_en", 32'(mem_r_en), 0);
    chk("ld_next_valid", 32'(valid), 1);

    // back-to-back store then load
    rst_pulse();
    mem_ready = 1'b0;
    drive(1, 0, 0, 1, 32'h600, 32'hdead_beef, 4'd0);
    step();
    drive(1, 1, 1, 0, 32'h700, 32'h0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      chk("st_freeze", 32'(freeze), 1);
      chk("st_w_en", 32'(mem_w_en), 1);
      chk("st_valid", 32'(valid), 1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("st_rel_freeze", 32'(freeze), 0);
    chk("st_alu", alu_result, 32'h600);
    chk("st_rm", rm_val, 32'hdead_beef);
    step();
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_freeze", 32'(freeze), 1);
      chk("b2b_r_en", 32'(mem_r_en), 1);
      chk("b2b_w_en", 32'(mem_w_en), 0);
      chk("b2b_alu", alu_result, 32'h700);
      chk("b2b_valid", 32'(valid), 1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("b2b_rel_freeze", 32'(freeze), 0);
    step();
    chk("b2b_valid_end", 32'(valid), 0);
    chk("b2b_stall", 32'(stall_cycles), 6);
    chk("b2b_freeze_end", 32'(freeze), 0);

    // SRAM timeout
    rst_pulse();
    mem_ready = 1'b0;
    drive(1, 1, 1, 0, 32'h800, 32'h0, 4'd2);
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("to_before", 32'(mem_timeout), 0);
    step();
    chk("to_set", 32'(mem_timeout), 1);
    chk("to_freeze", 32'(freeze), 1);
    chk("to_stall_sat", 32'(stall_cycles), 7);
    chk("to_alu", alu_result, 32'h800);
    step();
    step();
    chk("to_hold", 32'(mem_timeout), 1);
    chk("to_freeze2", 32'(freeze), 1);
    mem_ready = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    #1;
    chk("to_rel_freeze", 32'(freeze), 0);
    step();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_valid", 32'(valid), 0);
    chk("to_stall_stuck", 32'(stall_cycles), 7);
    rst_pulse();
    chk("to_cleared", 32'(mem_timeout), 0);

    // bubble carrying a read enable
    mem_ready = 1'b0;
    drive(0, 1, 1, 0, 32'h900, 32'h0, 4'd4);
    step();
    chk("bub_valid", 32'(valid), 0);
    chk("bub_r_en", 32'(mem_r_en), 0);
    chk("bub_wb", 32'(wb_en), 0);
    chk("bub_alu", alu_result, 32'h900);
    chk("bub_freeze", 32'(freeze), 0);
    step();
    chk("bub_stall", 32'(stall_cycles), 0);

    // reset during WAIT
    drive(1, 1, 1, 0, 32'ha00, 32'h0, 4'd6);
    step();
    step();
    chk("rw_freeze_pre", 32'(freeze), 1);
    #3 rst = 1'b0;
    #1;
    chk("rw_freeze", 32'(freeze), 0);
    chk("rw_r_en", 32'(mem_r_en), 0);
    chk("rw_wb", 32'(wb_en), 0);
    chk("rw_valid", 32'(valid), 0);
    mem_ready = 1'b1;
    #1 rst = 1'b1;
    drive(1, 1, 1, 0, 32'hb00, 32'h0, 4'd8);
    step();
    chk("rw_new_alu", alu_result, 32'hb00);
    chk("rw_new_freeze", 32'(freeze), 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    step();
    chk("rw_retired", 32'(valid), 0);
    chk("rw_stall", 32'(stall_cycles), 0);
    chk("rw_to", 32'(mem_timeout), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
